// File: rtl/reservation_station.sv
// Issue queue between rename and execute: holds dispatched micro-ops until both
// source operands are ready, then presents the lowest-index ready entry.
module reservation_station #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 6,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [PREG_W-1:0] in_ps1,
  input  logic [PREG_W-1:0] in_ps2,
  input  logic [PREG_W-1:0] in_pd,
  input  logic [31:0]       in_instr,
  input  logic              in_rdy1,
  input  logic              in_rdy2,
  input  logic              wb_valid,
  input  logic [PREG_W-1:0] wb_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_opcode,
  output logic [PREG_W-1:0] out_ps1,
  output logic [PREG_W-1:0] out_ps2,
  output logic [PREG_W-1:0] out_pd,
  output logic [31:0]       out_instr,
  output logic [CNT_W-1:0]  count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic              valid_r  [DEPTH];
  logic [6:0]        opcode_r [DEPTH];
  logic [PREG_W-1:0] ps1_r    [DEPTH];
  logic [PREG_W-1:0] ps2_r    [DEPTH];
  logic [PREG_W-1:0] pd_r     [DEPTH];
  logic [31:0]       instr_r  [DEPTH];
  logic              rdy1_r   [DEPTH];
  logic              rdy2_r   [DEPTH];
  logic [CNT_W-1:0]  count_r;

  logic [DEPTH-1:0]  issuable_s;
  logic [DEPTH-1:0]  free_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic [IDX_W-1:0]  free_idx_s;
  logic              dispatch_s;
  logic              issue_s;
  logic              disp_rdy1_s;
  logic              disp_rdy2_s;

  // Per-entry issuable and free flags, from registered state only
  always_comb begin
    issuable_s = '0;
    free_s     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      issuable_s[i] = valid_r[i] & rdy1_r[i] & rdy2_r[i];
      free_s[i]     = ~valid_r[i];
    end
  end

  // Lowest-index priority pick for issue and for dispatch slot
  always_comb begin
    sel_idx_s  = '0;
    free_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (issuable_s[i]) begin
        sel_idx_s = IDX_W'(i);
      end else begin
        sel_idx_s = sel_idx_s;
      end
      if (free_s[i]) begin
        free_idx_s = IDX_W'(i);
      end else begin
        free_idx_s = free_idx_s;
      end
    end
  end

  assign in_ready   = (count_r < DEPTH_C) & ~flush;
  assign out_valid  = |issuable_s;
  assign dispatch_s = in_valid & in_ready;
  assign issue_s    = out_valid & out_ready;
  assign count      = count_r;

  // Tag 0 is hard-wired zero; a matching writeback in the dispatch cycle is bypassed in
  assign disp_rdy1_s = in_rdy1 | (wb_valid & (in_ps1 == wb_tag)) | (in_ps1 == '0);
  assign disp_rdy2_s = in_rdy2 | (wb_valid & (in_ps2 == wb_tag)) | (in_ps2 == '0);

  // Present the selected entry's fields, zeroed when nothing is issuable
  always_comb begin
    out_opcode = 7'd0;
    out_ps1    = '0;
    out_ps2    = '0;
    out_pd     = '0;
    out_instr  = 32'd0;
    if (out_valid) begin
      out_opcode = opcode_r[sel_idx_s];
      out_ps1    = ps1_r[sel_idx_s];
      out_ps2    = ps2_r[sel_idx_s];
      out_pd     = pd_r[sel_idx_s];
      out_instr  = instr_r[sel_idx_s];
    end else begin
      out_opcode = 7'd0;
      out_ps1    = '0;
      out_ps2    = '0;
      out_pd     = '0;
      out_instr  = 32'd0;
    end
  end

  // Entry storage: wakeup, issue clear and dispatch write; flush wins over all
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i]  <= 1'b0;
        opcode_r[i] <= 7'd0;
        ps1_r[i]    <= '0;
        ps2_r[i]    <= '0;
        pd_r[i]     <= '0;
        instr_r[i]  <= 32'd0;
        rdy1_r[i]   <= 1'b0;
        rdy2_r[i]   <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        rdy1_r[i]  <= 1'b0;
        rdy2_r[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_r[i] && wb_valid) begin
          if (ps1_r[i] == wb_tag) rdy1_r[i] <= 1'b1;
          if (ps2_r[i] == wb_tag) rdy2_r[i] <= 1'b1;
        end
        if (issue_s && (IDX_W'(i) == sel_idx_s)) valid_r[i] <= 1'b0;
        if (dispatch_s && (IDX_W'(i) == free_idx_s)) begin
          valid_r[i]  <= 1'b1;
          opcode_r[i] <= in_opcode;
          ps1_r[i]    <= in_ps1;
          ps2_r[i]    <= in_ps2;
          pd_r[i]     <= in_pd;
          instr_r[i]  <= in_instr;
          rdy1_r[i]   <= disp_rdy1_s;
          rdy2_r[i]   <= disp_rdy2_s;
        end
      end
    end
  end

  // Occupancy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (flush) begin
      count_r <= '0;
    end else begin
      case ({dispatch_s, issue_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issued entries are checked against a
// scoreboard queue filled as dispatches are driven.
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = 7'd0;
  logic [5:0]  in_ps1 = 6'd0;
  logic [5:0]  in_ps2 = 6'd0;
  logic [5:0]  in_pd = 6'd0;
  logic [31:0] in_instr = 32'd0;
  logic        in_rdy1 = 1'b0;
  logic        in_rdy2 = 1'b0;
  logic        wb_valid = 1'b0;
  logic [5:0]  wb_tag = 6'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [6:0]  out_opcode;
  logic [5:0]  out_ps1;
  logic [5:0]  out_ps2;
  logic [5:0]  out_pd;
  logic [31:0] out_instr;
  logic [3:0]  count;

  logic [56:0] sb[$];
  int n_vec = 0;
  int n_err = 0;

  reservation_station dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_ps1(in_ps1), .in_ps2(in_ps2), .in_pd(in_pd), .in_instr(in_instr),
    .in_rdy1(in_rdy1), .in_rdy2(in_rdy2),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd(out_pd), .out_instr(out_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [5:0] d);
    return 32'hC0DE_0000 | {26'd0, d};
  endfunction

  function automatic logic [56:0] rec(input logic [6:0] op, input logic [5:0] s1,
                                      input logic [5:0] s2, input logic [5:0] d);
    return {op, s1, s2, d, ins(d)};
  endfunction

  task automatic drive(input logic [6:0] op, input logic [5:0] s1, input logic [5:0] s2,
                       input logic [5:0] d, input logic r1, input logic r2);
    in_valid  = 1'b1;
    in_opcode = op;
    in_ps1    = s1;
    in_ps2    = s2;
    in_pd     = d;
    in_instr  = ins(d);
    in_rdy1   = r1;
    in_rdy2   = r2;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted issue must match the next expected entry
  always @(negedge clk) begin
    logic [56:0] exp_rec;
    if (!rst && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        exp_rec = sb.pop_front();
        chk("issue_fields", 64'({out_opcode, out_ps1, out_ps2, out_pd, out_instr}), 64'(exp_rec));
      end
    end
  end

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pd", 64'(out_pd), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Ready-at-dispatch entry issues the next cycle
    out_ready = 1'b1;
    drive(7'h33, 6'd5, 6'd6, 6'd9, 1'b1, 1'b1);
    sb.push_back(rec(7'h33, 6'd5, 6'd6, 6'd9));
    cyc(); in_valid = 1'b0; #1;
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_pd", 64'(out_pd), 64'd9);
    chk("t1_count", 64'(count), 64'd1);
    cyc(); #1;
    chk("t1_count_after", 64'(count), 64'd0);
    chk("t1_empty", 64'(out_valid), 64'd0);

    // Wakeup after a wait; issue one cycle after the wakeup edge
    drive(7'h13, 6'd12, 6'd3, 6'd20, 1'b0, 1'b1);
    sb.push_back(rec(7'h13, 6'd12, 6'd3, 6'd20));
    cyc(); in_valid = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold", 64'(out_valid), 64'd0);
      cyc();
    end
    wb_valid = 1'b1; wb_tag = 6'd12; #1;
    chk("t2_no_same_cycle", 64'(out_valid), 64'd0);
    cyc(); wb_valid = 1'b0; #1;
    chk("t2_woken", 64'(out_valid), 64'd1);
    chk("t2_pd", 64'(out_pd), 64'd20);
    drive(7'h03, 6'd50, 6'd51, 6'd21, 1'b0, 1'b0);
    cyc(); in_valid = 1'b0; #1;
    chk("t2_disp_issue_count", 64'(count), 64'd1);
    chk("t2_left_not_ready", 64'(out_valid), 64'd0);
    flush = 1'b1; #1;
    chk("t2_flush_in_ready", 64'(in_ready), 64'd0);
    cyc(); flush = 1'b0; #1;
    chk("t2_flush_count", 64'(count), 64'd0);

    // Fill to full; tag-0 sources are stored ready
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(7'h23, 6'(10 + i), 6'd0, 6'(30 + i), 1'b0, 1'b0);
      #1 chk("t3_fill_ready", 64'(in_ready), 64'd1);
      cyc();
    end
    in_valid = 1'b0; #1;
    chk("t3_full_count", 64'(count), 64'd8);
    chk("t3_full_in_ready", 64'(in_ready), 64'd0);
    drive(7'h23, 6'd60, 6'd0, 6'd62, 1'b1, 1'b1);
    cyc(); in_valid = 1'b0; #1;
    chk("t3_ninth_ignored", 64'(count), 64'd8);
    chk("t3_ninth_not_issuable", 64'(out_valid), 64'd0);
    wb_valid = 1'b1; wb_tag = 6'd13;
    cyc(); wb_valid = 1'b0; #1;
    chk("t3_woken", 64'(out_valid), 64'd1);
    chk("t3_woken_pd", 64'(out_pd), 64'd33);
    sb.push_back(rec(7'h23, 6'd13, 6'd0, 6'd33));
    out_ready = 1'b1; #1;
    chk("t3_no_same_cycle_ready", 64'(in_ready), 64'd0);
    cyc(); out_ready = 1'b0; #1;
    chk("t3_ready_after_issue", 64'(in_ready), 64'd1);
    chk("t3_count_after_issue", 64'(count), 64'd7);
    drive(7'h23, 6'd0, 6'd0, 6'd40, 1'b1, 1'b1);
    flush = 1'b1; #1;
    chk("t3_flush_blocks", 64'(in_ready), 64'd0);
    cyc(); flush = 1'b0; in_valid = 1'b0; #1;
    chk("t3_flush_count", 64'(count), 64'd0);
    chk("t3_flush_over_dispatch", 64'(out_valid), 64'd0);

    // Dispatch-cycle wakeup bypass
    out_ready = 1'b1;
    drive(7'h33, 6'd7, 6'd8, 6'd22, 1'b0, 1'b1);
    wb_valid = 1'b1; wb_tag = 6'd7;
    sb.push_back(rec(7'h33, 6'd7, 6'd8, 6'd22));
    cyc(); in_valid = 1'b0; wb_valid = 1'b0; #1;
    chk("t4_bypass_valid", 64'(out_valid), 64'd1);
    chk("t4_bypass_pd", 64'(out_pd), 64'd22);
    cyc(); #1;
    chk("t4_count", 64'(count), 64'd0);

    // Priority and stall: entries 2 and 5 ready
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(7'h63, 6'(20 + i), 6'(30 + i), 6'(40 + i), (i == 2 || i == 5), (i == 2 || i == 5));
      cyc();
    end
    in_valid = 1'b0; #1;
    chk("t5_pick_low", 64'(out_pd), 64'd42);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("t5_stable", 64'(out_pd), 64'd42);
    end
    sb.push_back(rec(7'h63, 6'd22, 6'd32, 6'd42));
    sb.push_back(rec(7'h63, 6'd25, 6'd35, 6'd45));
    out_ready = 1'b1;
    cyc(); #1;
    chk("t5_next", 64'(out_pd), 64'd45);
    chk("t5_count5", 64'(count), 64'd5);
    cyc(); out_ready = 1'b0; #1;
    chk("t5_drained", 64'(out_valid), 64'd0);
    chk("t5_count4", 64'(count), 64'd4);
    wb_valid = 1'b1; wb_tag = 6'd20;
    cyc(); wb_tag = 6'd30;
    cyc(); wb_valid = 1'b0; #1;
    chk("t5_pre_rst_valid", 64'(out_valid), 64'd1);

    // Asynchronous reset between edges with 4 entries held
    rst = 1'b1; #1;
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_out_pd", 64'(out_pd), 64'd0);
    rst = 1'b0; #1;
    chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    cyc(); #1;
    chk("t6_no_stale_issue", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Flush with 4 entries: clears only at the next edge
    for (int i = 0; i < 4; i++) begin
      drive(7'h0F, 6'(20 + i), 6'(30 + i), 6'(50 + i), (i == 1), (i == 1));
      cyc();
    end
    in_valid = 1'b0; #1;
    chk("t7_count4", 64'(count), 64'd4);
    chk("t7_valid", 64'(out_valid), 64'd1);
    flush = 1'b1; out_ready = 1'b1; #1;
    chk("t7_flush_not_immediate", 64'(count), 64'd4);
    cyc(); flush = 1'b0; out_ready = 1'b0; #1;
    chk("t7_flush_count", 64'(count), 64'd0);
    chk("t7_flush_valid", 64'(out_valid), 64'd0);

    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameters: DEPTH, default 8, number of entries; PREG_W, default 6, physical-register tag width; CNT_W, default 4, occupancy width (clog2(DEPTH)+1).
REQ-002 clk  input  1  rising-edge clock, only clock of the block.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 flush  input  1  synchronous clear of all entries.
REQ-005 in_valid  input  1  dispatch request from rename stage.
REQ-006 in_ready  output  1  block can accept a dispatch this cycle.
REQ-007 in_opcode  input  7  opcode from rename.
REQ-008 in_ps1, in_ps2, in_pd  input  PREG_W each  physical source 1, source 2 and destination tags.
REQ-009 in_instr  input  32  full instruction word, carried through unchanged.
REQ-010 in_rdy1, in_rdy2  input  1 each  source operand already available at dispatch.
REQ-011 wb_valid  input  1  writeback broadcast valid.
REQ-012 wb_tag  input  PREG_W  physical tag being written back.
REQ-013 out_valid  output  1  an issuable entry is presented.
REQ-014 out_ready  input  1  execute stage accepts the presented entry.
REQ-015 out_opcode 7, out_ps1 / out_ps2 / out_pd PREG_W, out_instr 32  outputs  fields of the issued entry.
REQ-016 count  output  CNT_W  number of occupied entries.

Function
REQ-017 Each entry holds valid, opcode, ps1, ps2, pd, instr, rdy1, rdy2; entry is issuable when valid & rdy1 & rdy2.
REQ-018 in_ready = (count < DEPTH) & ~flush, combinational from registered state; an entry freed by issue in this cycle does not raise in_ready in the same cycle.
REQ-019 Dispatch fires on in_valid & in_ready; fields are written into the lowest-index invalid entry at the clock edge; valid set.
REQ-020 Wakeup: on wb_valid, every valid entry with ps1 == wb_tag sets rdy1, and with ps2 == wb_tag sets rdy2, at the clock edge.
REQ-021 Wakeup bypass at dispatch: stored rdy1 = in_rdy1 | (wb_valid & in_ps1 == wb_tag); likewise rdy2.
REQ-022 Tag 0 is architectural zero: a source with tag 0 is always stored ready.
REQ-023 Selection: out_valid = any entry issuable; presented entry is the lowest-index issuable entry; out_* fields come combinationally from that entry; out_* are 0 when out_valid = 0.
REQ-024 Issue fires on out_valid & out_ready; the presented entry's valid is cleared at the clock edge; maximum one issue per cycle.
REQ-025 Wakeup in the same cycle does not make an entry issuable until the next cycle (no same-cycle wakeup-to-issue).
REQ-026 Simultaneous dispatch and issue: count unchanged; both updates take effect.
REQ-027 count increments by 1 on dispatch only, decrements by 1 on issue only; never exceeds DEPTH or goes below 0.
REQ-028 Dispatch with in_valid while full: ignored, no state change; upstream holds request.
REQ-029 out_valid held with out_ready low: presented entry is unchanged next cycle unless a lower-index entry became issuable.
REQ-030 flush: next edge clears all valid bits and count to 0; flush overrides dispatch, issue and wakeup in that cycle.

Reset
REQ-031 rst asserted: immediately, with no clock edge, all entry valid and ready bits and count become 0; out_valid = 0, all out_* = 0, in_ready = 1 once rst deasserts.
REQ-032 rst asserted mid-operation discards all held entries; no issue occurs from pre-reset state.

Verification
REQ-033 Dispatch opcode 0x33, ps1=5, ps2=6, pd=9, rdy1=rdy2=1, out_ready=1 -> next cycle out_valid=1, out_pd=9; following cycle count=0.
REQ-034 Dispatch ps1=12 rdy1=0, rdy2=1; hold 3 cycles, then wb_valid, wb_tag=12 -> out_valid rises exactly one cycle after the wakeup edge.
REQ-035 Dispatch 8 non-ready entries -> count=8, in_ready=0; 9th in_valid ignored; wakeup one entry and issue it -> in_ready=1 the cycle after issue.
REQ-036 Dispatch ps1=7 rdy1=0 in the same cycle as wb_valid, wb_tag=7 -> entry stored ready, issuable next cycle.
REQ-037 Entries in indexes 2 and 5 ready, out_ready=0 for 2 cycles -> index 2 presented, stable; out_ready=1 -> index 2 issued, then index 5.
REQ-038 With 4 entries held, assert rst between edges -> count=0 and out_valid=0 immediately; same with flush -> cleared at next edge.
